// File: rtl/serdes_tx_sched_32b_8b.sv
// Round-robin scheduler sharing one 32-to-8 serializer among NUM_REQ word sources.
// Each granted word goes out MSB byte first over four clk_4f cycles.
module serdes_tx_sched_32b_8b #(
    parameter int          NUM_REQ   = 4,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic                    clk_4f,
    input  logic                    reset_L,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic                    valid_out,
    output logic [7:0]              data_out,
    output logic [2:0]              grant_id,
    output logic                    busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [1:0]           cnt;
    logic [2:0]           last;
    logic [23:0]          shreg;

    logic                 arb_edge;
    logic                 any_req;
    logic                 hi_found;
    logic [2:0]           lo_idx;
    logic [2:0]           hi_idx;
    logic [2:0]           winner;
    logic [31:0]          word_sel;
    logic [NUM_REQ-1:0]   ack_onehot;

    assign arb_edge   = (state == IDLE) || (cnt == 2'd3);
    assign any_req    = |req_valid;
    assign ack_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

    // Lowest set index above last wins; otherwise wrap to the lowest set index overall.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = 3'(i);
                if (i > int'(last)) begin
                    hi_idx   = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == winner)
                word_sel = req_data[32*i +: 32];
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 3'(NUM_REQ - 1);
            shreg     <= '0;
            valid_out <= 1'b0;
            data_out  <= IDLE_BYTE;
            req_ack   <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            req_ack <= '0;
            if (arb_edge) begin
                if (enable && any_req) begin
                    state     <= SEND;
                    busy      <= 1'b1;
                    valid_out <= 1'b1;
                    cnt       <= '0;
                    data_out  <= word_sel[31:24];
                    shreg     <= word_sel[23:0];
                    grant_id  <= winner;
                    last      <= winner;
                end else begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    valid_out <= 1'b0;
                    cnt       <= '0;
                    data_out  <= IDLE_BYTE;
                end
            end else begin
                cnt      <= cnt + 2'd1;
                data_out <= shreg[23:16];
                shreg    <= {shreg[15:0], 8'h00};
                // Ack rides with byte [15:8] so the requester can refresh at the last byte.
                if (cnt == 2'd1)
                    req_ack <= ack_onehot;
            end
        end
    end

endmodule

// File: tb/tb_serdes_tx_sched_32b_8b.sv
// Scoreboard bench for serdes_tx_sched_32b_8b: stimulus queues expected bytes,
// a negedge monitor pops and compares whenever valid_out is high.
module tb_serdes_tx_sched_32b_8b;

    localparam int NUM_REQ = 4;

    logic                  clk_4f;
    logic                  reset_L;
    logic                  enable;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  valid_out;
    logic [7:0]            data_out;
    logic [2:0]            grant_id;
    logic                  busy;

    typedef struct {
        logic [7:0] data;
        logic [2:0] gid;
        logic [3:0] ack;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    serdes_tx_sched_32b_8b #(
        .NUM_REQ   (NUM_REQ),
        .IDLE_BYTE (8'h00)
    ) dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .enable    (enable),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .valid_out (valid_out),
        .data_out  (data_out),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial begin
        clk_4f = 1'b0;
        forever #5 clk_4f = ~clk_4f;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input int g);
        exp_t e;
        for (int b = 0; b < 4; b++) begin
            e.data = w[31-8*b -: 8];
            e.gid  = 3'(g);
            e.ack  = (b == 2) ? 4'(1 << g) : 4'h0;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        req_data[32*i +: 32] = w;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_4f);
        #2;
    endtask

    task automatic check_idle(input string tag, input logic [2:0] gid);
        chk({tag, "_valid"}, 32'(valid_out), 32'h0);
        chk({tag, "_data"},  32'(data_out),  32'h0);
        chk({tag, "_busy"},  32'(busy),      32'h0);
        chk({tag, "_ack"},   32'(req_ack),   32'h0);
        chk({tag, "_gid"},   32'(grant_id),  32'(gid));
    endtask

    task automatic reset_dut();
        reset_L   = 1'b0;
        req_valid = '0;
        enable    = 1'b1;
        cycles(2);
        check_idle("reset", 3'd0);
        reset_L = 1'b1;
    endtask

    // Monitor: compares each valid byte against the scoreboard; idle cycles must be quiet.
    always @(negedge clk_4f) begin
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none at %0t", data_out, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(mon_e.data));
                chk("grant_id", 32'(grant_id), 32'(mon_e.gid));
                chk("req_ack",  32'(req_ack),  32'(mon_e.ack));
                chk("busy",     32'(busy),     32'h1);
            end
        end else begin
            chk("idle_data", 32'(data_out), 32'h0);
            chk("idle_ack",  32'(req_ack),  32'h0);
            chk("idle_busy", 32'(busy),     32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_L   = 1'b0;
        enable    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        #1;
        check_idle("async_reset", 3'd0);

        // 1: single requester, same word three times back-to-back
        reset_dut();
        set_word(0, 32'hA1B2C3D4);
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) push_word(32'hA1B2C3D4, 0);
        cycles(12);
        req_valid = '0;
        cycles(3);

        // 2: all requesters valid, two full rounds starting at 0
        reset_dut();
        for (int i = 0; i < 4; i++) set_word(i, 32'(i) << 4);
        req_valid = 4'b1111;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) push_word(32'(i) << 4, i);
        cycles(32);
        req_valid = '0;
        cycles(3);

        // 3: requester 1 granted, then 1 and 3 alternate starting with 3
        reset_dut();
        set_word(1, 32'h11223344);
        set_word(3, 32'h99AABBCC);
        req_valid = 4'b0010;
        push_word(32'h11223344, 1);
        cycles(4);
        req_valid = 4'b1010;
        push_word(32'h99AABBCC, 3);
        push_word(32'h11223344, 1);
        push_word(32'h99AABBCC, 3);
        cycles(12);
        req_valid = '0;
        cycles(3);
        check_idle("rr_after", 3'd3);

        // 4: enable dropped while byte [23:16] is on the output
        set_word(0, 32'hDEADBEEF);
        req_valid = 4'b0001;
        push_word(32'hDEADBEEF, 0);
        cycles(2);
        enable = 1'b0;
        cycles(3);
        check_idle("en_off", 3'd0);
        cycles(2);
        check_idle("en_off_hold", 3'd0);
        req_valid = '0;
        enable    = 1'b1;
        cycles(1);

        // 5: asynchronous reset while byte [23:16] is out, then requester 0 first
        set_word(2, 32'h55667788);
        req_valid = 4'b0100;
        exp_q.push_back('{data: 8'h55, gid: 3'd2, ack: 4'h0});
        exp_q.push_back('{data: 8'h66, gid: 3'd2, ack: 4'h0});
        cycles(2);
        @(negedge clk_4f);
        #1;
        reset_L = 1'b0;
        #1;
        check_idle("mid_reset", 3'd0);
        req_valid = '0;
        cycles(2);
        reset_L = 1'b1;
        set_word(0, 32'h0A0B0C0D);
        set_word(1, 32'h1A1B1C1D);
        set_word(2, 32'h2A2B2C2D);
        set_word(3, 32'h3A3B3C3D);
        req_valid = 4'b1111;
        push_word(32'h0A0B0C0D, 0);
        cycles(4);
        req_valid = '0;
        cycles(3);

        // 6: data changed after grant does not disturb the word in flight
        set_word(0, 32'h01234567);
        req_valid = 4'b0001;
        push_word(32'h01234567, 0);
        push_word(32'hFFFFFFFF, 0);
        cycles(1);
        set_word(0, 32'hFFFFFFFF);
        cycles(7);
        req_valid = '0;
        cycles(3);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk_4f);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
